// File: rtl/btn_pkg.sv
// Shared types and constants for the pushbutton conditioner.
// Default timing assumes a 100 MHz system clock.
package btn_pkg;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_PRESS = 2'd1,
        S_HELD       = 2'd2,
        S_WAIT_REL   = 2'd3
    } btn_state_e;

    // Bit positions within the {right, left, down, up} button vector.
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    localparam int unsigned N_BTN_DEF           = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned REPEAT_DELAY_DEF    = 50000000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 10000000;

    // Counter width able to hold 0 .. n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the pixel stage.
// slave = the conditioner, master = whoever drives btn_raw and consumes the strobes.
interface btn_conditioner_if
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN = N_BTN_DEF
);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability-count debounce FSM, press/release strobes.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat on btn_press.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta_q;
    logic             sync_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_done;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rpt_fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            sync_meta_q <= btn_raw;
            sync_q      <= sync_meta_q;
        end
    end

    // State register; the outputs are registered alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign cnt_done = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (sync_q) begin
                    state_d = S_WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            S_WAIT_PRESS: begin
                if (!sync_q) begin
                    state_d = S_IDLE;
                end else if (cnt_done) begin
                    state_d = S_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HELD: begin
                if (!sync_q) begin
                    state_d = S_WAIT_REL;
                    cnt_d   = '0;
                end
            end
            S_WAIT_REL: begin
                if (sync_q) begin
                    state_d = S_HELD;
                end else if (cnt_done) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
    localparam int unsigned      RPT_W          = cnt_width(RPT_SPAN);
    localparam logic [RPT_W-1:0] RPT_DELAY_MAX  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_MAX = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_armed_q, rpt_armed_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end

    // rpt_armed selects the initial delay versus the steady repeat period.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_fire    = 1'b0;
        if (state_q == S_WAIT_PRESS && state_d == S_HELD) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end else if (state_q == S_HELD && state_d == S_HELD) begin
            if (rpt_cnt_q == (rpt_armed_q ? RPT_PERIOD_MAX : RPT_DELAY_MAX)) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end else if (state_q == S_IDLE) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end
    end
`else
    // Repeat timing is only consumed when auto-repeat is built in.
    localparam int unsigned unused_rpt_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        level_d   = (state_d == S_HELD) || (state_d == S_WAIT_REL);
        press_d   = ((state_q == S_WAIT_PRESS) && (state_d == S_HELD)) || rpt_fire;
        release_d = (state_q == S_WAIT_REL) && (state_d == S_IDLE);
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw pushbuttons into debounced levels plus one-cycle press/release strobes.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat on btn_press.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    btn_conditioner_if.slave bus
);

    // Channels are fully independent; simultaneous events appear in the same cycle.
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .btn_raw     (bus.btn_raw[i]),
            .btn_level   (bus.btn_level[i]),
            .btn_press   (bus.btn_press[i]),
            .btn_release (bus.btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expected strobes are queued with their due cycle
// when stimulus is applied and compared against the DUT every cycle.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned DB   = 8;
    localparam int unsigned RD   = 20;
    localparam int unsigned RP   = 6;
    localparam int unsigned LAT  = DB + 3;
    localparam int unsigned HOLD = 58;

    typedef struct {
        int unsigned at;
        int unsigned ch;
        bit          rel;
    } evt_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    evt_t        sb[$];
    logic [N-1:0] exp_level = '0;

    btn_conditioner_if #(.N_BTN(N)) bus ();

    btn_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_evt(input int unsigned at, input int unsigned ch, input bit rel);
        evt_t e;
        e.at  = at;
        e.ch  = ch;
        e.rel = rel;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pop events due this cycle and compare all outputs, mid-cycle.
    always @(negedge clk) begin
        logic [N-1:0] ep;
        logic [N-1:0] er;
        ep = '0;
        er = '0;
        if (!reset_n) begin
            exp_level = '0;
        end else begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    if (sb[i].rel) er[sb[i].ch] = 1'b1;
                    else           ep[sb[i].ch] = 1'b1;
                    sb.delete(i);
                end
            end
            exp_level = (exp_level | ep) & ~er;
        end
        check_val("press", 32'(bus.btn_press), 32'(ep));
        check_val("release", 32'(bus.btn_release), 32'(er));
        check_val("level", 32'(bus.btn_level), 32'(exp_level));
    end

    initial begin
        int unsigned c;
        int unsigned acc;

        reset_n     = 1'b0;
        bus.btn_raw = '1;
        step(30);

        // Reset release with all buttons already held: full re-qualification.
        reset_n = 1'b1;
        c = cyc;
        for (int ch = 0; ch < N; ch++) push_evt(c + LAT, ch, 1'b0);
        step(20);
        bus.btn_raw = '0;
        c = cyc;
        for (int ch = 0; ch < N; ch++) push_evt(c + LAT, ch, 1'b1);
        step(20);

        // Clean press and release on up.
        bus.btn_raw[BTN_UP] = 1'b1;
        push_evt(cyc + LAT, BTN_UP, 1'b0);
        step(40);
        bus.btn_raw[BTN_UP] = 1'b0;
        push_evt(cyc + LAT, BTN_UP, 1'b1);
        step(20);

        // Bouncing down button: 3-cycle segments never qualify.
        for (int k = 0; k < 10; k++) begin
            bus.btn_raw[BTN_DOWN] = (k % 2 == 0);
            step(3);
        end
        bus.btn_raw[BTN_DOWN] = 1'b1;
        push_evt(cyc + LAT, BTN_DOWN, 1'b0);
        step(20);
        bus.btn_raw[BTN_DOWN] = 1'b0;
        push_evt(cyc + LAT, BTN_DOWN, 1'b1);
        step(20);

        // Left: press, short low glitch ignored, then real release.
        bus.btn_raw[BTN_LEFT] = 1'b1;
        push_evt(cyc + LAT, BTN_LEFT, 1'b0);
        step(20);
        bus.btn_raw[BTN_LEFT] = 1'b0;
        step(5);
        bus.btn_raw[BTN_LEFT] = 1'b1;
        step(20);
        bus.btn_raw[BTN_LEFT] = 1'b0;
        push_evt(cyc + LAT, BTN_LEFT, 1'b1);
        step(20);

        // Right: reset lands with the counter at 4, then re-qualification.
        bus.btn_raw[BTN_RIGHT] = 1'b1;
        step(7);
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        acc = cyc + LAT;
        push_evt(acc, BTN_RIGHT, 1'b0);
`ifdef BTN_AUTOREPEAT_EN
        for (int unsigned t = acc + RD; t <= acc + HOLD + 2; t += RP) begin
            push_evt(t, BTN_RIGHT, 1'b0);
        end
`endif
        step(LAT + HOLD);
        bus.btn_raw[BTN_RIGHT] = 1'b0;
        push_evt(cyc + LAT, BTN_RIGHT, 1'b1);
        step(20);

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
